clock_div_monitor: RTL and testbench
====================================

# clock_div_monitor

Receive-side companion to the team's clock dividers. It samples a divided clock that is generated synchronously from `clk`, emits single-cycle rise/fall strobes, and measures the divided clock's period in `clk` cycles. A lock state machine declares the divided clock good after a run of correct periods and flags mismatches or stalls. Downstream logic uses the strobes as clock enables and gates on `locked` instead of clocking from the divided signal.

## Interface
Parameters:
- `EXP_PERIOD`, default 4: expected divided-clock period, in `clk` cycles. Must be ≥ 2.
- `CNT_W`, default 8: width of the period counter and of `period`.
- `LOCK_CNT`, default 3: number of consecutive matching periods required to lock. Must be ≥ 1.
- `TIMEOUT`, default 16: cycles without a rising edge before stall is declared. Require EXP_PERIOD < TIMEOUT < 2^CNT_W − 1.

Ports:
- `clk`  in  1  system clock; all logic is on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `in_clk`  in  1  divided clock, synchronous to `clk`; no synchronizer is used.
- `rise_pulse`  out  1  one-cycle strobe for an `in_clk` rising edge.
- `fall_pulse`  out  1  one-cycle strobe for an `in_clk` falling edge.
- `period`  out  CNT_W  last measured rise-to-rise period.
- `locked`  out  1  high while in the LOCK state.
- `err_pulse`  out  1  one-cycle strobe on a period mismatch or a timeout.

## Operation
Edge detection:
- `in_q` holds `in_clk` delayed by one cycle.
- `rise_det` = `in_clk & ~in_q`; `fall_det` = `~in_clk & in_q`.
- `rise_pulse` and `fall_pulse` are registered copies of these detections.

Period counter `per_cnt` (CNT_W bits):
- Loads 1 on `rise_det`.
- Otherwise increments, saturating at 2^CNT_W − 1.
- At `rise_det`, the pre-load value of `per_cnt` is the measured period.
- `period` updates with the measured value only on rises taken in ACQ or LOCK. It holds otherwise.
- A match is measured == EXP_PERIOD.
- A timeout is `per_cnt` == TIMEOUT with no `rise_det` in that cycle.

FSM states: IDLE, ACQ, LOCK. Match counter `match_cnt` is ⌈log2(LOCK_CNT+1)⌉ bits.
- IDLE:
  - `rise_det` → ACQ, with `match_cnt` = 0.
  - Timeouts are ignored; `per_cnt` saturates.
- ACQ:
  - `rise_det` with a match → `match_cnt`+1. On reaching LOCK_CNT → LOCK.
  - `rise_det` with a mismatch → `match_cnt` = 0, stay in ACQ, `err_pulse`.
  - Timeout → IDLE, `err_pulse`.
- LOCK:
  - `rise_det` with a match → stay in LOCK.
  - `rise_det` with a mismatch → ACQ, `match_cnt` = 0, `err_pulse`.
  - Timeout → IDLE, `err_pulse`.

Boundary rules:
- `rise_det` has priority over a timeout in the same cycle. A rise arriving exactly at `per_cnt` == TIMEOUT is evaluated as a mismatch.
- The first rise after IDLE only starts measurement; it is never compared.
- A constant `in_clk` (stuck high or stuck low) ends in IDLE via timeout.

## Timing
Reset values (applied on the first posedge with `rst` = 1):
- `in_q` = 0, `per_cnt` = 0, state = IDLE, `match_cnt` = 0.
- All outputs = 0, including `period` = 0.

Latencies:
- `rise_pulse`, `fall_pulse`, `err_pulse`, `period` and `locked` are all registered. Each changes on the posedge after the cycle where `in_clk` shows the edge.
- Strobe latency is one `clk` cycle after `in_clk` changes.

Other cycle-level rules:
- `locked` rises one cycle after the LOCK_CNT-th matching rise is detected. It falls one cycle after a mismatching rise or a timeout is detected.
- `rst` asserted mid-operation: every register returns to its reset value on that edge. This clears `locked` and drops any strobe in flight.
- If `rst` is high while `in_clk` is high, `in_q` is 0 after reset. A `rise_pulse` follows on the first post-reset cycle, and it counts as the IDLE→ACQ rise.

## Test plan
1. **Nominal lock.** Defaults; `in_clk` is a div-by-4 square wave (2 high, 2 low) starting after reset.
   - Rise 1: IDLE→ACQ.
   - Rises 2–4: `period` = 4.
   - `locked` = 1 one cycle after rise 4.
   - Strobes alternate rise/fall every 2 cycles; `err_pulse` never fires.
2. **Mismatch while locked.** After lock, stretch one low phase by 1 cycle (period 5).
   - `period` = 5, `err_pulse` for 1 cycle, `locked` = 0.
   - `locked` returns one cycle after 3 further good periods.
3. **Stall timeout.** After lock, hold `in_clk` = 0.
   - 16 cycles after the last rise: `err_pulse` for 1 cycle, `locked` = 0, state IDLE.
   - `period` holds 4.
4. **Rise at the timeout boundary.** In ACQ, next rise arrives when `per_cnt` = 16.
   - Exactly one `err_pulse`, state ACQ (not IDLE), `period` = 16.
5. **Mid-lock reset.** Assert `rst` for 1 cycle while locked.
   - Next cycle: all outputs 0.
   - Re-lock after 4 rises with identical timing to scenario 1.
6. **Parameter variant.** EXP_PERIOD = 6, LOCK_CNT = 1, with a div-by-6 input.
   - `locked` after the second rise.
   - A div-by-4 input never locks and emits `err_pulse` on every rise after the first.

Source files
------------

// File: rtl/clock_div_monitor.sv
// clock_div_monitor: edge strobes, period measurement and lock
// tracking for a divided clock generated synchronously from clk.
module clock_div_monitor #(
  parameter int EXP_PERIOD = 4,
  parameter int CNT_W      = 8,
  parameter int LOCK_CNT   = 3,
  parameter int TIMEOUT    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_clk,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic [CNT_W-1:0] period,
  output logic             locked,
  output logic             err_pulse
);

  localparam int MC_W = $clog2(LOCK_CNT + 1);
  localparam int MCP  = MC_W + 1;

  localparam logic [CNT_W-1:0] EXP_V = CNT_W'(EXP_PERIOD);
  localparam logic [CNT_W-1:0] TO_V  = CNT_W'(TIMEOUT);
  localparam logic [MC_W:0]    LCK_V = MCP'(LOCK_CNT);

  typedef enum logic [1:0] {
    IDLE,
    ACQ,
    LOCK
  } state_t;

  state_t           state;
  logic             in_q;
  logic [CNT_W-1:0] per_cnt;
  logic [MC_W-1:0]  match_cnt;
  logic             rise_det;
  logic             fall_det;
  logic             match;
  logic             tmo;
  logic [MC_W:0]    mc_nxt;

  assign rise_det = in_clk & ~in_q;
  assign fall_det = ~in_clk & in_q;
  assign match    = (per_cnt == EXP_V);
  // a rise in the timeout cycle wins and is judged as a period
  assign tmo      = (per_cnt == TO_V) & ~rise_det;
  assign mc_nxt   = {1'b0, match_cnt} + MCP'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      in_q       <= 1'b0;
      per_cnt    <= '0;
      match_cnt  <= '0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
      period     <= '0;
      locked     <= 1'b0;
      err_pulse  <= 1'b0;
    end else begin
      in_q       <= in_clk;
      rise_pulse <= rise_det;
      fall_pulse <= fall_det;
      err_pulse  <= 1'b0;

      if (rise_det)
        per_cnt <= CNT_W'(1);
      else if (per_cnt != '1)
        per_cnt <= per_cnt + CNT_W'(1);

      unique case (state)
        IDLE: begin
          if (rise_det) begin
            state     <= ACQ;
            match_cnt <= '0;
          end
        end
        ACQ: begin
          if (rise_det) begin
            period <= per_cnt;
            if (match) begin
              match_cnt <= mc_nxt[MC_W-1:0];
              if (mc_nxt == LCK_V) begin
                state  <= LOCK;
                locked <= 1'b1;
              end
            end else begin
              match_cnt <= '0;
              err_pulse <= 1'b1;
            end
          end else if (tmo) begin
            state     <= IDLE;
            err_pulse <= 1'b1;
          end
        end
        LOCK: begin
          if (rise_det) begin
            period <= per_cnt;
            if (!match) begin
              state     <= ACQ;
              match_cnt <= '0;
              locked    <= 1'b0;
              err_pulse <= 1'b1;
            end
          end else if (tmo) begin
            state     <= IDLE;
            locked    <= 1'b0;
            err_pulse <= 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          locked <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clock_div_monitor.sv
// tb_clock_div_monitor: two monitors (default and EXP=6/LOCK=1) on
// one divided clock, checked against an event-level period model.
module tb_clock_div_monitor;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_clk = 1'b0;
  logic       r0, f0, l0, e0;
  logic       r1, f1, l1, e1;
  logic [7:0] p0, p1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  clock_div_monitor dut0 (
    .clk(clk), .rst(rst), .in_clk(in_clk),
    .rise_pulse(r0), .fall_pulse(f0),
    .period(p0), .locked(l0), .err_pulse(e0)
  );

  clock_div_monitor #(
    .EXP_PERIOD(6), .LOCK_CNT(1)
  ) dut1 (
    .clk(clk), .rst(rst), .in_clk(in_clk),
    .rise_pulse(r1), .fall_pulse(f1),
    .period(p1), .locked(l1), .err_pulse(e1)
  );

  localparam int TMO = 16;
  localparam int SAT = 255;

  int   m_exp[2] = '{4, 6};
  int   m_lck[2] = '{3, 1};
  bit   m_prev[2];
  int   m_age[2];
  int   m_mode[2];
  int   m_run[2];
  int   m_per[2];
  logic m_rise[2], m_fall[2], m_err[2], m_lock[2];

  // mode: 0 idle, 1 acquiring, 2 locked; age = cycles since last rise
  task automatic model_step();
    bit rise;
    int meas;
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_prev[i] = 0; m_age[i] = 0; m_mode[i] = 0; m_run[i] = 0;
        m_per[i] = 0; m_rise[i] = 0; m_fall[i] = 0; m_err[i] = 0;
      end else begin
        rise = in_clk && !m_prev[i];
        m_rise[i] = rise;
        m_fall[i] = !in_clk && m_prev[i];
        m_prev[i] = in_clk;
        m_err[i] = 0;
        if (rise) begin
          meas = (m_age[i] > SAT) ? SAT : m_age[i];
          m_age[i] = 1;
          if (m_mode[i] == 0) begin
            m_mode[i] = 1;
            m_run[i] = 0;
          end else begin
            m_per[i] = meas;
            if (meas == m_exp[i]) begin
              m_run[i]++;
              if (m_run[i] >= m_lck[i]) m_mode[i] = 2;
            end else begin
              m_run[i] = 0;
              m_mode[i] = 1;
              m_err[i] = 1;
            end
          end
        end else begin
          if (m_age[i] == TMO && m_mode[i] != 0) begin
            m_mode[i] = 0;
            m_err[i] = 1;
          end
          m_age[i]++;
        end
      end
      m_lock[i] = (m_mode[i] == 2);
    end
  endtask

  function automatic logic [23:0] got();
    return {r1, f1, e1, l1, p1, r0, f0, e0, l0, p0};
  endfunction

  function automatic logic [23:0] want();
    return {m_rise[1], m_fall[1], m_err[1], m_lock[1], 8'(m_per[1]),
            m_rise[0], m_fall[0], m_err[0], m_lock[0], 8'(m_per[0])};
  endfunction

  task automatic step(input logic r, input logic v);
    @(negedge clk);
    rst = r;
    in_clk = v;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    checks++;
    if (got() !== 24'h0) begin
      errors++;
      $display("FAIL reset_zero got=%h exp=000000", got());
    end
    step(1'b0, 1'b1);
    checks++;
    if (r0 !== 1'b1 || r1 !== 1'b1 || l0 !== 1'b0) begin
      errors++;
      $display("FAIL reset_high_rise got r0=%b r1=%b l0=%b exp 1 1 0", r0, r1, l0);
    end
    checks++;
    if (got() !== want()) begin
      errors++;
      $display("FAIL reset_model got=%h exp=%h", got(), want());
    end
    step(1'b1, 1'b0);
  endtask

  task automatic run_nominal(input string tag);
    int rises, errs0, errs1;
    logic [1:0] sx;
    rises = 0; errs0 = 0; errs1 = 0;
    step(1'b1, 1'b0);
    checks++;
    if (got() !== 24'h0) begin
      errors++;
      $display("FAIL %s_rst_zero got=%h exp=000000", tag, got());
    end
    for (int p = 0; p < 6; p++) begin
      for (int c = 0; c < 4; c++) begin
        step(1'b0, c < 2);
        checks++;
        if (got() !== want()) begin
          errors++;
          $display("FAIL %s_model p=%0d c=%0d got=%h exp=%h", tag, p, c, got(), want());
        end
        sx = (c == 0) ? 2'b10 : ((c == 2) ? 2'b01 : 2'b00);
        checks++;
        if ({r0, f0} !== sx) begin
          errors++;
          $display("FAIL %s_strobe p=%0d c=%0d got=%b exp=%b", tag, p, c, {r0, f0}, sx);
        end
        errs0 += int'(e0);
        errs1 += int'(e1);
        if (c == 0) begin
          rises++;
          if (rises == 3) begin
            checks++;
            if (l0 !== 1'b0) begin
              errors++;
              $display("FAIL %s_early_lock got=%b exp=0", tag, l0);
            end
          end
          if (rises == 4) begin
            checks++;
            if (l0 !== 1'b1 || p0 !== 8'd4) begin
              errors++;
              $display("FAIL %s_lock got l=%b p=%0d exp l=1 p=4", tag, l0, p0);
            end
          end
        end
      end
    end
    checks++;
    if (errs0 !== 0) begin
      errors++;
      $display("FAIL %s_no_err got=%0d exp=0", tag, errs0);
    end
    checks++;
    if (errs1 !== rises - 1) begin
      errors++;
      $display("FAIL %s_div4_on_exp6 got=%0d exp=%0d", tag, errs1, rises - 1);
    end
  endtask

  task automatic test_mismatch();
    int lo_len[6] = '{3, 2, 2, 2, 2, 2};
    for (int k = 0; k < 6; k++) begin
      for (int c = 0; c < 2 + lo_len[k]; c++) begin
        step(1'b0, c < 2);
        checks++;
        if (got() !== want()) begin
          errors++;
          $display("FAIL mismatch_model k=%0d c=%0d got=%h exp=%h", k, c, got(), want());
        end
        if (k == 1 && c == 0) begin
          checks++;
          if (p0 !== 8'd5 || e0 !== 1'b1 || l0 !== 1'b0) begin
            errors++;
            $display("FAIL mismatch_hit got p=%0d e=%b l=%b exp p=5 e=1 l=0", p0, e0, l0);
          end
        end
        if (k == 1 && c == 1) begin
          checks++;
          if (e0 !== 1'b0) begin
            errors++;
            $display("FAIL mismatch_err_len got=%b exp=0", e0);
          end
        end
        if (c == 0 && (k == 3 || k == 4)) begin
          checks++;
          if (l0 !== (k == 4)) begin
            errors++;
            $display("FAIL mismatch_relock k=%0d got=%b exp=%b", k, l0, k == 4);
          end
        end
      end
    end
  endtask

  task automatic test_stall();
    for (int j = 0; j < 21; j++) begin
      step(1'b0, j < 2);
      checks++;
      if (got() !== want()) begin
        errors++;
        $display("FAIL stall_model j=%0d got=%h exp=%h", j, got(), want());
      end
      if (j == 15 || j == 16 || j == 17) begin
        checks++;
        if (e0 !== (j == 16) || l0 !== (j < 16) || p0 !== 8'd4) begin
          errors++;
          $display("FAIL stall_tmo j=%0d got e=%b l=%b p=%0d exp e=%b l=%b p=4",
                   j, e0, l0, p0, j == 16, j < 16);
        end
      end
    end
  endtask

  task automatic test_boundary();
    int lo_len[5] = '{14, 2, 2, 2, 2};
    int errs;
    errs = 0;
    for (int k = 0; k < 5; k++) begin
      for (int c = 0; c < 2 + lo_len[k]; c++) begin
        step(1'b0, c < 2);
        checks++;
        if (got() !== want()) begin
          errors++;
          $display("FAIL boundary_model k=%0d c=%0d got=%h exp=%h", k, c, got(), want());
        end
        if (k < 2) errs += int'(e0);
        if (k == 1 && c == 0) begin
          checks++;
          if (p0 !== 8'd16 || e0 !== 1'b1 || l0 !== 1'b0) begin
            errors++;
            $display("FAIL boundary_rise got p=%0d e=%b l=%b exp p=16 e=1 l=0", p0, e0, l0);
          end
        end
        if (k == 4 && c == 0) begin
          checks++;
          if (l0 !== 1'b1) begin
            errors++;
            $display("FAIL boundary_acq_lock got=%b exp=1", l0);
          end
        end
      end
    end
    checks++;
    if (errs !== 1) begin
      errors++;
      $display("FAIL boundary_err_count got=%0d exp=1", errs);
    end
  endtask

  task automatic test_midreset();
    step(1'b0, 1'b1);
    checks++;
    if (l0 !== 1'b1 || r0 !== 1'b1) begin
      errors++;
      $display("FAIL midreset_pre got l=%b r=%b exp l=1 r=1", l0, r0);
    end
    run_nominal("midreset");
  endtask

  task automatic test_variant();
    int errs1;
    errs1 = 0;
    step(1'b1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      for (int c = 0; c < 6; c++) begin
        step(1'b0, c < 3);
        checks++;
        if (got() !== want()) begin
          errors++;
          $display("FAIL variant_model k=%0d c=%0d got=%h exp=%h", k, c, got(), want());
        end
        errs1 += int'(e1);
        if (c == 0 && k < 2) begin
          checks++;
          if (l1 !== (k == 1) || (k == 1 && p1 !== 8'd6)) begin
            errors++;
            $display("FAIL variant_lock k=%0d got l=%b p=%0d exp l=%b p=6", k, l1, p1, k == 1);
          end
        end
      end
    end
    checks++;
    if (errs1 !== 0) begin
      errors++;
      $display("FAIL variant_no_err got=%0d exp=0", errs1);
    end
  endtask

  task automatic test_random();
    bit lv[$];
    bit seg_rst;
    int kind, hi, lo, n;
    bit lvl;
    for (int s = 0; s < 80; s++) begin
      lv.delete();
      seg_rst = 0;
      kind = $urandom_range(0, 9);
      if (kind == 0) begin
        seg_rst = 1;
        lv.push_back(1'($urandom_range(0, 1)));
      end else if (kind == 1) begin
        lvl = 1'($urandom_range(0, 1));
        n = $urandom_range(10, 40);
        for (int i = 0; i < n; i++) lv.push_back(lvl);
      end else begin
        if (kind <= 5) begin
          hi = 2; lo = 2;
        end else if (kind == 6) begin
          hi = 3; lo = 3;
        end else begin
          hi = $urandom_range(1, 4);
          lo = $urandom_range(1, 4);
        end
        for (int i = 0; i < hi; i++) lv.push_back(1'b1);
        for (int i = 0; i < lo; i++) lv.push_back(1'b0);
      end
      for (int i = 0; i < lv.size(); i++) begin
        step(seg_rst, lv[i]);
        checks++;
        if (got() !== want()) begin
          errors++;
          $display("FAIL random_model s=%0d i=%0d got=%h exp=%h", s, i, got(), want());
        end
      end
    end
  endtask

  initial begin
    test_reset();
    run_nominal("nominal");
    test_mismatch();
    test_stall();
    test_boundary();
    test_midreset();
    test_variant();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
